// File: rtl/fp32_skid_stage.sv
// fp32_skid_stage: registered valid/ready stage with a 2-entry skid buffer
// for FP32 operands, presenting each operand with registered class flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is a flop)
//   in_data             FP32 bit pattern from upstream
//   out_valid/out_ready downstream handshake
//   out_data            registered operand
//   out_is_zero/inf/nan/denorm  registered class flags for out_data
module fp32_skid_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_is_zero,
   output logic             out_is_inf,
   output logic             out_is_nan,
   output logic             out_is_denorm
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   // flag vector order: {zero, inf, nan, denorm}
   function automatic logic [3:0] classify(input logic [30:0] d);
      logic [7:0]  e;
      logic [22:0] m;
      e = d[30:23];
      m = d[22:0];
      classify = {(e == 8'h00) && (m == 23'd0),
                  (e == 8'hFF) && (m == 23'd0),
                  (e == 8'hFF) && (m != 23'd0),
                  (e == 8'h00) && (m != 23'd0)};
   endfunction

   logic [1:0]       state;
   logic [WIDTH-1:0] main_data;
   logic [3:0]       main_flags;
   logic [WIDTH-1:0] skid_data;
   logic [3:0]       skid_flags;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [3:0]       in_flags;
   logic             accept;
   logic             drain;

   assign in_flags = classify(in_data[30:0]);
   assign accept   = in_valid & in_ready_q;
   assign drain    = out_valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_data   <= '0;
         main_flags  <= '0;
         skid_data   <= '0;
         skid_flags  <= '0;
      end else begin
         unique case (state)
            S_EMPTY: begin
               if (accept) begin
                  main_data   <= in_data;
                  main_flags  <= in_flags;
                  out_valid_q <= 1'b1;
                  state       <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && drain) begin
                  main_data  <= in_data;
                  main_flags <= in_flags;
               end else if (accept) begin
                  skid_data  <= in_data;
                  skid_flags <= in_flags;
                  in_ready_q <= 1'b0;
                  state      <= S_TWO;
               end else if (drain) begin
                  // flags must read 0 while nothing is presented
                  out_valid_q <= 1'b0;
                  main_flags  <= '0;
                  state       <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (drain) begin
                  main_data  <= skid_data;
                  main_flags <= skid_flags;
                  in_ready_q <= 1'b1;
                  state      <= S_ONE;
               end
            end
            default: begin
               state       <= S_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               main_flags  <= '0;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_data      = main_data;
   assign out_is_zero   = main_flags[3];
   assign out_is_inf    = main_flags[2];
   assign out_is_nan    = main_flags[1];
   assign out_is_denorm = main_flags[0];

endmodule

// File: tb/tb_fp32_skid_stage.sv
// tb_fp32_skid_stage: directed and random stimulus for fp32_skid_stage,
// checked against a queue model and literal expectations.
module tb_fp32_skid_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_is_zero;
   logic        out_is_inf;
   logic        out_is_nan;
   logic        out_is_denorm;
   logic [3:0]  flg;

   int total = 0;
   int bad   = 0;

   fp32_skid_stage #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_is_zero   (out_is_zero),
      .out_is_inf    (out_is_inf),
      .out_is_nan    (out_is_nan),
      .out_is_denorm (out_is_denorm)
   );

   assign flg = {out_is_zero, out_is_inf, out_is_nan, out_is_denorm};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // class from the field definitions: {zero, inf, nan, denorm}
   function automatic logic [3:0] cls(input logic [31:0] v);
      int unsigned e;
      int unsigned m;
      e = v[30:23];
      m = v[22:0];
      return {e == 0 && m == 0, e == 255 && m == 0,
              e == 255 && m != 0, e == 0 && m != 0};
   endfunction

   // model: everything accepted and not yet drained, in order
   logic [31:0] q[$];
   logic [31:0] obs_d[$];
   logic [3:0]  obs_f[$];
   int          obs_c[$];
   int          cyc = 0;
   bit          started = 0;
   bit          stall_prev = 0;
   logic [31:0] prev_d;
   logic [3:0]  prev_f;

   always @(negedge clk) begin
      bit acc;
      bit drn;
      cyc++;
      if (started) begin
         chk("valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
         chk("ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
         if (q.size() > 0) begin
            chk("data", out_data, q[0]);
            chk("flags", {28'd0, flg}, {28'd0, cls(q[0])});
         end else begin
            chk("flags_idle", {28'd0, flg}, 32'd0);
         end
         if (stall_prev) begin
            chk("stall_data", out_data, prev_d);
            chk("stall_flags", {28'd0, flg}, {28'd0, prev_f});
         end
      end
      if (rst) begin
         q.delete();
         started = 1;
         stall_prev = 0;
      end else if (started) begin
         drn = (out_valid === 1'b1) && out_ready;
         acc = in_valid && (in_ready === 1'b1);
         if (drn) begin
            obs_d.push_back(out_data);
            obs_f.push_back(flg);
            obs_c.push_back(cyc);
            if (q.size() > 0) void'(q.pop_front());
         end
         if (acc) q.push_back(in_data);
         stall_prev = (out_valid === 1'b1) && !out_ready;
         prev_d = out_data;
         prev_f = flg;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data = d;
      n = 0;
      do begin
         acc = in_ready;
         step();
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rnd_op();
      logic        s;
      logic [22:0] m;
      s = 1'($urandom());
      m = 23'($urandom());
      case ($urandom_range(0, 5))
         0: return {s, 8'h00, 23'd0};
         1: return {s, 8'hFF, 23'd0};
         2: return {s, 8'hFF, m | 23'd1};
         3: return {s, 8'h00, m | 23'd1};
         default: return $urandom();
      endcase
   endfunction

   logic [31:0] cls_in[7];
   logic [3:0]  cls_exp[7];

   initial begin
      int base;
      int sent;
      int guard;
      bit acc;
      cls_in  = '{32'h00000000, 32'h80000000, 32'h7F800000,
                  32'hFF800000, 32'h7FC00000, 32'h00000001,
                  32'h40490FDB};
      cls_exp = '{4'b1000, 4'b1000, 4'b0100, 4'b0100,
                  4'b0010, 4'b0001, 4'b0000};
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_data", out_data, 32'd0);

      // first operand, one-cycle latency
      out_ready = 1'b1;
      push(32'h3F800000);
      chk("first_valid", {31'd0, out_valid}, 32'd1);
      chk("first_data", out_data, 32'h3F800000);
      chk("first_flags", {28'd0, flg}, 32'd0);
      step();

      // classification
      base = obs_d.size();
      for (int i = 0; i < 7; i++) push(cls_in[i]);
      repeat (3) step();
      chk("cls_count", obs_d.size() - base, 32'd7);
      for (int i = 0; i < 7 && base + i < obs_d.size(); i++) begin
         chk("cls_data", obs_d[base+i], cls_in[i]);
         chk("cls_flags", {28'd0, obs_f[base+i]}, {28'd0, cls_exp[i]});
      end

      // backpressure
      out_ready = 1'b0;
      base = obs_d.size();
      push(32'h11111111);
      push(32'h22222222);
      in_valid = 1'b1;
      in_data = 32'h33333333;
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold", out_data, 32'h11111111);
         if (i < 2) step();
      end
      chk("bp_none", obs_d.size() - base, 32'd0);
      out_ready = 1'b1;
      step();
      chk("bp_b", out_data, 32'h22222222);
      chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_c", out_data, 32'h33333333);
      step();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);
      chk("bp_count", obs_d.size() - base, 32'd3);
      if (obs_d.size() - base == 3) begin
         chk("bp_o0", obs_d[base], 32'h11111111);
         chk("bp_o1", obs_d[base+1], 32'h22222222);
         chk("bp_o2", obs_d[base+2], 32'h33333333);
      end

      // full throughput
      base = obs_d.size();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data = 32'h40000000 | i;
         chk("tp_ready", {31'd0, in_ready}, 32'd1);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      chk("tp_count", obs_d.size() - base, 32'd16);
      for (int i = 0; i < 16 && base + i < obs_d.size(); i++) begin
         chk("tp_data", obs_d[base+i], 32'h40000000 | i);
         chk("tp_cycle", obs_c[base+i] - obs_c[base], i);
      end

      // reset while holding two entries
      out_ready = 1'b0;
      push(32'hAAAA0001);
      push(32'hBBBB0002);
      chk("mr_full", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_ready", {31'd0, in_ready}, 32'd1);
      base = obs_d.size();
      out_ready = 1'b1;
      repeat (5) step();
      chk("mr_none", obs_d.size() - base, 32'd0);

      // random traffic
      base = obs_d.size();
      sent = 0;
      guard = 0;
      while (sent < 1000 && guard < 20000) begin
         if (!in_valid && $urandom_range(0, 9) < 7) begin
            in_valid = 1'b1;
            in_data = rnd_op();
         end
         out_ready = ($urandom_range(0, 2) != 0);
         acc = in_valid && in_ready;
         step();
         guard++;
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      chk("rnd_budget", sent, 32'd1000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < 50) begin
         step();
         guard++;
      end
      chk("rnd_drained", q.size(), 32'd0);
      chk("rnd_count", obs_d.size() - base, 32'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp32_skid_stage.md
Name: fp32_skid_stage

Overview:
- Registered valid/ready pipeline stage for 32-bit IEEE-754 single-precision operands.
- Sits directly upstream of the FPU datapath registers and feeds them.
- Breaks the ready path with a 2-entry skid buffer.
- Presents each accepted operand registered, together with registered class flags (zero/inf/NaN/denormal), so the downstream stage needs no combinational decode.

Parameters:
- WIDTH, 32, operand width in bits. Only 32 is supported; the flag decode assumes 1 sign, 8 exponent and 23 mantissa bits.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream operand valid
- in_ready  output  1  stage can accept; registered output
- in_data  input  WIDTH  upstream operand, FP32 bit pattern
- out_valid  output  1  out_data and flags valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  registered operand
- out_is_zero  output  1  exponent 0 and mantissa 0 (either sign)
- out_is_inf  output  1  exponent 0xFF and mantissa 0
- out_is_nan  output  1  exponent 0xFF and mantissa nonzero
- out_is_denorm  output  1  exponent 0 and mantissa nonzero

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values, applied on the edge with rst=1:
  - out_valid=0, out_data=0, all out_is_* =0, in_ready=1.
  - Skid entry cleared.
  - State EMPTY.
- Reset mid-operation discards both held entries with no output. rst overrides every handshake in that cycle.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main register drives the outputs; the skid register holds data and flags when main is stalled.
- Class flags are decoded from the data being loaded and registered with it. They are always consistent with out_data. They are 0 whenever out_valid=0.
- State machine:
  - EMPTY (out_valid=0, in_ready=1):
    - accept -> ONE; main <= in_data.
  - ONE (out_valid=1, in_ready=1):
    - accept & drain -> ONE; main <= in_data.
    - accept & !drain -> TWO; skid <= in_data; in_ready <= 0.
    - !accept & drain -> EMPTY; out_valid <= 0.
    - otherwise hold.
  - TWO (out_valid=1, in_ready=0):
    - drain -> ONE; main <= skid; in_ready <= 1.
    - otherwise hold.
    - in_valid and in_data are ignored.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY. Full throughput is 1 operand per cycle with out_ready held high.
- Ordering: strict FIFO order. No drops, no duplicates.
- Stall rule: while out_valid=1 and out_ready=0, out_data and the flags hold stable.
- in_ready depends only on flops, never combinationally on out_ready.
- in_valid with in_ready=0 has no effect. Upstream must hold in_data until accepted.
- Flag decode is bit-exact:
  - Exponent = data[30:23], mantissa = data[22:0].
  - The sign bit does not affect any flag.
  - Exactly one flag or none is set; a normal number sets none.

Test Plan:
- Reset then stream: assert rst 2 cycles; check out_valid=0, in_ready=1, out_data=0. Then send 0x3F800000 with out_ready=1 -> out_valid=1 and out_data=0x3F800000 next cycle, all flags 0.
- Classification: stream 0x00000000, 0x80000000, 0x7F800000, 0xFF800000, 0x7FC00000, 0x00000001, 0x40490FDB with out_ready=1 -> flags in order zero, zero, inf, inf, nan, denorm, none; data unchanged.
- Backpressure: out_ready=0, offer A=0x11111111, B=0x22222222, C=0x33333333 back-to-back:
  - A is held on the outputs, B sits in skid, in_ready=0 and C is not accepted.
  - Raise out_ready -> outputs A, B, C in order, 1 per cycle once C is accepted; in_ready returns to 1 the cycle after A drains.
- Full throughput: 16 consecutive operands with in_valid=1 and out_ready=1 -> 16 outputs on consecutive cycles, in_ready never 0.
- Reset mid-operation: in TWO holding A and B, pulse rst 1 cycle -> out_valid=0 and in_ready=1 the next cycle, and neither A nor B ever appears.
- Random stall: 1000 random operands with random in_valid/out_ready -> scoreboard exact order match, and stable outputs during every stall.
